// File: rtl/trng_word_packer_if.sv
// Word-side valid/ready port of the TRNG word packer.
interface trng_word_packer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;

    // Producer side: the packer presents words.
    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    // Consumer side: host register / DMA.
    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/trng_word_packer.sv
// Packs the debiased TRNG bit stream LSB-first into words, guards it with a
// repetition-count health test and buffers words in a small FIFO.
module trng_word_packer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RCT_LIMIT = 34,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     flush,
    trng_word_packer_if.master       word_if,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     health_fail,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0] RUN_TRIP = RW'(RCT_LIMIT);

    // Partial word holds at most WIDTH-1 bits; the last bit joins on the push.
    logic [WIDTH-2:0] shreg_q;
    logic [BW-1:0]    bit_cnt_q;
    // run_q == 0 means no previous bit since reset/flush.
    logic [RW-1:0]    run_q;
    logic             prev_q;
    logic             fail_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [CNT_W-1:0] drop_q;

    logic             hb_bit;
    logic [RW-1:0]    run_nxt;
    logic             trip;
    logic             pack;
    logic             word_done;
    logic [WIDTH-1:0] new_word;
    logic             pop;
    logic             full;
    logic             do_push;
    logic             drop;

    // Health test, packing and FIFO handshake decisions for this edge.
    always_comb begin
        hb_bit    = bit_valid & ~fail_q & ~flush;
        run_nxt   = (run_q != '0 && bit_in == prev_q) ? run_q + RW'(1) : RW'(1);
        trip      = hb_bit && (run_nxt == RUN_TRIP);
        pack      = hb_bit && !trip;
        word_done = pack && (bit_cnt_q == LAST_BIT);
        new_word  = {bit_in, shreg_q};
        pop       = word_if.word_valid && word_if.word_ready;
        full      = (count_q == FULL_LVL);
        do_push   = word_done && (!full || pop);
        drop      = word_done && full && !pop;
    end

    // Bit accumulation and sticky repetition-count state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            prev_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (flush) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            prev_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (hb_bit) begin
            prev_q <= bit_in;
            run_q  <= run_nxt;
            if (trip) begin
                // Tripping bit is not packed and the partial word is discarded.
                fail_q    <= 1'b1;
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                shreg_q   <= new_word[WIDTH-1:1];
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
            end
        end
    end

    // Word FIFO with saturating drop counter; flush empties it but keeps drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= new_word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop && drop_q != '1) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign word_if.word_valid = (count_q != '0);
    assign word_if.word_data  = mem_q[rd_ptr_q];
    assign fill_level         = count_q;
    assign health_fail        = fail_q;
    assign drop_count         = drop_q;

endmodule
